// File: rtl/rv32i_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   boot_state_e : loader FSM states
//   IMEM_DEPTH   : default instruction memory size in 32-bit words
package rv32i_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    BYTE,
    WRITE,
    CHK,
    RUN,
    ERROR
  } boot_state_e;

  localparam int IMEM_DEPTH = 64;

endpackage

// File: rtl/boot_word_assembler.sv
// Assembles little-endian 32-bit words from a byte stream and keeps an
// 8-bit additive checksum of every byte taken in.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart byte lane and checksum (start of a payload)
//   byte_valid  : byte_in is consumed this cycle
//   byte_in     : incoming payload byte
//   word        : assembled word (complete once last_byte was consumed)
//   sum         : running payload sum, modulo 256
//   byte_idx    : lane the next byte lands in
//   last_byte   : next byte completes a word
module boot_word_assembler
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [7:0]  sum,
  output logic [1:0]  byte_idx,
  output logic        last_byte
);

  logic [31:0] word_q, word_d;
  logic [7:0]  sum_q, sum_d;
  logic [1:0]  byte_idx_q, byte_idx_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    word_d     = word_q;
    sum_d      = sum_q;
    byte_idx_d = byte_idx_q;
    if (clear) begin
      byte_idx_d = 2'd0;
      sum_d      = 8'd0;
    end else if (byte_valid) begin
      // Lane byte_idx holds bits [8*byte_idx +: 8]: first byte is the LSB.
      word_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
      sum_d      = sum_q + byte_in;
      byte_idx_d = byte_idx_q + 2'd1;   // wraps 3 -> 0 for the next word
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      word_q     <= '0;
      sum_q      <= '0;
      byte_idx_q <= '0;
    end else begin
      word_q     <= word_d;
      sum_q      <= sum_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  assign word      = word_q;
  assign sum       = sum_q;
  assign byte_idx  = byte_idx_q;
  assign last_byte = (byte_idx_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream (16-bit word count, payload,
// checksum), writes the payload words into the instruction memory and holds
// the CPU in reset until a load completes with a matching checksum.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   load_start          : restart a load from RUN or ERROR
//   rx_data/rx_valid    : incoming byte stream
//   rx_ready            : byte accepted this cycle when rx_valid is also high
//   mem_we/mem_waddr/mem_wdata : instruction memory write port
//   cpu_hold            : keeps the CPU core in reset while high
//   load_done           : one-cycle pulse on entry to RUN
//   load_err            : high while in ERROR
//   overflow            : sticky, header word count exceeded DEPTH
module imem_boot_loader
  import rv32i_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic              overflow
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  boot_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic        rx_ready_q, rx_ready_d;
  logic        load_done_q, load_done_d;
  logic        overflow_q, overflow_d;

  logic        xfer;
  logic [15:0] new_cnt;
  logic [15:0] word_idx_inc;
  logic        restart;
  logic        asm_clear;
  logic        asm_valid;
  logic [31:0] asm_word;
  logic [7:0]  asm_sum;
  logic [1:0]  asm_byte_idx;
  logic        asm_last;

  assign xfer         = rx_valid && rx_ready_q;
  assign new_cnt      = {rx_data, cnt_q[7:0]};
  assign word_idx_inc = word_idx_q + 16'd1;
  assign restart      = load_start && (state_q == RUN || state_q == ERROR);
  assign asm_clear    = (state_q == HDR_HI) && xfer;
  assign asm_valid    = (state_q == BYTE) && xfer;

  boot_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .word       (asm_word),
    .sum        (asm_sum),
    .byte_idx   (asm_byte_idx),
    .last_byte  (asm_last)
  );

  // State register and all loader flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR_LO;
      cnt_q       <= '0;
      word_idx_q  <= '0;
      rx_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_idx_q  <= word_idx_d;
      rx_ready_q  <= rx_ready_d;
      load_done_q <= load_done_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_LO: if (xfer) state_d = HDR_HI;
      HDR_HI: if (xfer) state_d = (new_cnt == 16'd0) ? CHK : BYTE;
      BYTE:   if (xfer && asm_last) state_d = WRITE;
      WRITE:  state_d = (word_idx_inc == cnt_q) ? CHK : BYTE;
      CHK:    if (xfer) state_d = (rx_data == asm_sum) ? RUN : ERROR;
      RUN,
      ERROR:  if (load_start) state_d = HDR_LO;
      default: state_d = HDR_LO;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    cnt_d       = cnt_q;
    word_idx_d  = word_idx_q;
    overflow_d  = overflow_q;
    // rx_ready follows the state being entered so it is a clean flop output.
    rx_ready_d  = (state_d == HDR_LO) || (state_d == HDR_HI) ||
                  (state_d == BYTE)   || (state_d == CHK);
    load_done_d = (state_d == RUN) && (state_q != RUN);

    if (state_q == HDR_LO && xfer) cnt_d[7:0] = rx_data;
    if (state_q == HDR_HI && xfer) begin
      cnt_d[15:8] = rx_data;
      word_idx_d  = 16'd0;
      if ({1'b0, new_cnt} > DEPTH_L) overflow_d = 1'b1;
    end
    if (state_q == WRITE) word_idx_d = word_idx_inc;
    if (restart) overflow_d = 1'b0;
  end

  // Words past the end of memory are consumed but dropped, never wrapped.
  assign mem_we    = (state_q == WRITE) && ({1'b0, word_idx_q} < DEPTH_L);
  assign mem_waddr = word_idx_q[ADDR_W-1:0];
  assign mem_wdata = asm_word;
  assign rx_ready  = rx_ready_q;
  assign cpu_hold  = (state_q != RUN);
  assign load_done = load_done_q;
  assign load_err  = (state_q == ERROR);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic        overflow;

  imem_boot_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [5:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] mem_model[64];
  int          done_cnt = 0;
  int          we_ready_viol = 0;
  logic [7:0]  frame_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Observe the memory port and pulses one step after each active edge.
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      wr_addr_q.push_back(mem_waddr);
      wr_data_q.push_back(mem_wdata);
      mem_model[mem_waddr] = mem_wdata;
      if (rx_ready) we_ready_viol++;
    end
    if (load_done) done_cnt++;
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt      = 0;
    we_ready_viol = 0;
  endtask

  // Called at a negedge; holds reset for two edges, returns at a negedge.
  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    load_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents one byte and returns at the negedge after it was transferred.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 9) >= 3) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_frame(input bit gaps);
    foreach (frame_q[i]) send_byte(frame_q[i], gaps);
    rx_valid = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (cpu_hold && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, cpu_hold}, 32'd0);
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic set_good_frame();
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
                8'h93, 8'h05, 8'h75, 8'h00, 8'h75};
  endtask

  // Expected outcome of the 2-word frame: 0x00500513 @0, 0x00750593 @1.
  task automatic check_two_words(input string tag);
    check({tag, "_nwr"}, wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check({tag, "_a0"}, {26'd0, wr_addr_q[0]}, 32'd0);
      check({tag, "_d0"}, wr_data_q[0], 32'h0050_0513);
      check({tag, "_a1"}, {26'd0, wr_addr_q[1]}, 32'd1);
      check({tag, "_d1"}, wr_data_q[1], 32'h0075_0593);
    end
  endtask

  logic [7:0]  big_bytes[260];
  logic [7:0]  big_sum;
  logic [31:0] big_word;
  int          data_err;

  initial begin
    foreach (mem_model[i]) mem_model[i] = 32'd0;

    // ---- Reset values ----
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cpu_hold",  {31'd0, cpu_hold},  32'd1);
    check("rst_rx_ready",  {31'd0, rx_ready},  32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_waddr",     {26'd0, mem_waddr}, 32'd0);
    check("rst_wdata",     mem_wdata,          32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_load_err",  {31'd0, load_err},  32'd0);
    check("rst_overflow",  {31'd0, overflow},  32'd0);
    reset = 1'b0;

    // ---- Good 2-word frame, rx_valid held high ----
    clear_log();
    set_good_frame();
    send_frame(1'b0);
    wait_run("t1_run");
    repeat (3) @(negedge clk);
    check_two_words("t1");
    check("t1_done_cnt", done_cnt, 1);
    check("t1_we_ready", we_ready_viol, 0);
    check("t1_load_err", {31'd0, load_err}, 32'd0);

    // ---- Bad checksum, then recovery via load_start ----
    do_reset();
    clear_log();
    set_good_frame();
    frame_q[10] = 8'h76;
    send_frame(1'b0);
    repeat (3) @(negedge clk);
    check("t2_done_cnt", done_cnt, 0);
    check("t2_load_err", {31'd0, load_err}, 32'd1);
    check("t2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("t2_rx_ready", {31'd0, rx_ready}, 32'd0);
    pulse_load_start();
    check("t2_err_clr",  {31'd0, load_err}, 32'd0);
    check("t2_hold_rst", {31'd0, cpu_hold}, 32'd1);
    clear_log();
    set_good_frame();
    send_frame(1'b0);
    wait_run("t2_run");
    repeat (2) @(negedge clk);
    check_two_words("t2");
    check("t2_done2", done_cnt, 1);

    // ---- N = 0 ----
    do_reset();
    clear_log();
    frame_q = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    wait_run("t3_run");
    repeat (2) @(negedge clk);
    check("t3_nwr", wr_addr_q.size(), 0);
    check("t3_done_cnt", done_cnt, 1);

    // ---- N = 65: one word beyond memory ----
    do_reset();
    clear_log();
    foreach (mem_model[i]) mem_model[i] = 32'd0;
    big_sum = 8'd0;
    for (int i = 0; i < 260; i++) begin
      big_bytes[i] = 8'((i * 37 + 11) & 255);
      big_sum = big_sum + big_bytes[i];
    end
    frame_q.delete();
    frame_q.push_back(8'h41);
    frame_q.push_back(8'h00);
    for (int i = 0; i < 260; i++) frame_q.push_back(big_bytes[i]);
    frame_q.push_back(big_sum);
    send_frame(1'b0);
    wait_run("t4_run");
    repeat (2) @(negedge clk);
    check("t4_nwr", wr_addr_q.size(), 64);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    check("t4_done_cnt", done_cnt, 1);
    data_err = 0;
    for (int w = 0; w < 64; w++) begin
      big_word = {big_bytes[4*w+3], big_bytes[4*w+2], big_bytes[4*w+1], big_bytes[4*w]};
      if (w < wr_addr_q.size()) begin
        if (wr_addr_q[w] !== 6'(w) || wr_data_q[w] !== big_word) data_err++;
      end
    end
    check("t4_data", data_err, 0);
    big_word = {big_bytes[3], big_bytes[2], big_bytes[1], big_bytes[0]};
    check("t4_no_wrap", mem_model[0], big_word);
    pulse_load_start();
    check("t4_ovf_clr", {31'd0, overflow}, 32'd0);

    // ---- Random rx_valid gaps ----
    do_reset();
    clear_log();
    set_good_frame();
    send_frame(1'b1);
    wait_run("t5_run");
    repeat (2) @(negedge clk);
    check_two_words("t5");
    check("t5_done_cnt", done_cnt, 1);

    // ---- load_start in BYTE is ignored ----
    do_reset();
    clear_log();
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93};
    send_frame(1'b0);
    pulse_load_start();
    check("t6_hold", {31'd0, cpu_hold}, 32'd1);
    frame_q = '{8'h05, 8'h75, 8'h00, 8'h75};
    send_frame(1'b0);
    wait_run("t6_run");
    repeat (2) @(negedge clk);
    check_two_words("t6");

    // ---- Reset during the second word, then full reload ----
    do_reset();
    foreach (mem_model[i]) mem_model[i] = 32'd0;
    frame_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05};
    send_frame(1'b0);
    do_reset();
    check("t7_rst_hold", {31'd0, cpu_hold}, 32'd1);
    clear_log();
    set_good_frame();
    send_frame(1'b0);
    wait_run("t7_run");
    repeat (2) @(negedge clk);
    check_two_words("t7");
    check("t7_mem0", mem_model[0], 32'h0050_0513);
    check("t7_mem1", mem_model[1], 32'h0075_0593);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
